// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: bit-centre tick generator for the UART receiver, a small
// first-word-fall-through byte FIFO, and overrun / framing-error status.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BITS   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            phase_arm,
  input  logic [FRAME_BITS-1:0]           rx_data,
  input  logic                            valid,
  input  logic                            frame_error,
  input  logic                            rd_en,
  input  logic                            clr_status,
  output logic                            center_tick,
  output logic                            busy,
  output logic [FRAME_BITS-1:0]           fifo_dout,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overrun,
  output logic [7:0]                      err_count
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TW   = $clog2(FRAME_BITS + 2);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] idx_q, idx_d;

  // Tick FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Tick FSM next state: count down to each bit centre, re-phase on arm.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that do not assign it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    center_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (phase_arm && enable) begin
          state_d = RUN;
          cnt_d   = CW'(HALF - 1);
          idx_d   = '0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (phase_arm) begin
          // False start: restart from the start-bit centre, drop this tick.
          cnt_d = CW'(HALF - 1);
          idx_d = '0;
        end else if (cnt_q == '0) begin
          center_tick = 1'b1;
          cnt_d       = CW'(CLKS_PER_BIT - 1);
          if (idx_q == TW'(FRAME_BITS + 1)) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);

  // ---------------------------------------------------------------- FIFO
  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [NW-1:0]         count;
  logic                  push, pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == NW'(FIFO_DEPTH));
  assign fifo_count = count;
  assign pop        = rd_en && !fifo_empty;
  assign push       = valid && (!fifo_full || pop);
  assign fifo_dout  = fifo_empty ? '0 : mem[rd_ptr];

  // Byte storage write port.
  // NOTE: the storage array is deliberately not reset; fifo_dout is masked
  // while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // Pointers and occupancy; pointers wrap naturally as depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // -------------------------------------------------------------- status
  logic fe_q;
  logic err_event, ovr_event;

  assign err_event = frame_error && !fe_q;
  assign ovr_event = valid && !push;

  // Sticky overrun and saturating error count; a new event beats clr_status.
  always_ff @(posedge clk) begin
    if (reset) begin
      fe_q      <= 1'b0;
      overrun   <= 1'b0;
      err_count <= '0;
    end else begin
      fe_q <= frame_error;
      if (ovr_event)       overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (clr_status)      err_count <= err_event ? 8'd1 : 8'd0;
      else if (err_event && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing and buffering controller for the UART receive path. It generates the bit-centre sampling strobes consumed by the receiver FSM, re-phasing on each start-bit arm pulse. It collects completed bytes into a small first-word-fall-through FIFO for the downstream command logic, and keeps overrun and framing-error status. It sits between the synchronised RX front end/receiver and the application.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (≥4); HALF = floor(CLKS_PER_BIT/2)
- FRAME_BITS, 8, data bits per frame; must match the receiver
- FIFO_DEPTH, 4, byte FIFO depth; power of two, ≥2
- clk  in  1  system clock; everything is on the rising edge
- reset  in  1  synchronous, active-high; one clock, sampled on rising clk
- enable  in  1  when low, no ticks are generated and phase_arm is ignored
- phase_arm  in  1  one-cycle start-edge pulse from the receiver
- rx_data  in  FRAME_BITS  received byte; qualified by valid
- valid  in  1  one-cycle byte-complete pulse
- frame_error  in  1  receiver framing-error flag
- rd_en  in  1  pops the FIFO head
- clr_status  in  1  clears overrun and err_count
- center_tick  out  1  one-cycle bit-centre strobe to the receiver
- busy  out  1  tick generator is in RUN
- fifo_dout  out  FRAME_BITS  FIFO head; valid while !fifo_empty
- fifo_empty  out  1  FIFO holds 0 entries
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_count  out  clog2(FIFO_DEPTH+1)  number of entries
- overrun  out  1  sticky: a byte was dropped
- err_count  out  8  saturating count of framing errors

## Operation
- Reset values: center_tick=0, busy=0, fifo_dout=0, fifo_empty=1, fifo_full=0, fifo_count=0, overrun=0, err_count=0. Tick FSM is in IDLE. Pointers are 0.
- Tick FSM has two states, IDLE and RUN, with a down-counter and a tick counter (0..FRAME_BITS+1).
- IDLE, phase_arm && enable: go to RUN. Load counter so the first tick lands at the start-bit centre. Set tick counter to 0.
- RUN: emit FRAME_BITS+2 ticks total: start bit, data bits, stop bit. After the last tick, return to IDLE in the same cycle.
- RUN, phase_arm && enable (false start re-arm): restart the sequence from the first tick. Phase_arm has priority over a tick in the same cycle; that tick is suppressed.
- enable falling in RUN: go to IDLE next cycle. No further ticks are emitted.
- FIFO push on valid:
  - Accepted if !fifo_full, or if rd_en pops in the same cycle.
  - Otherwise the byte is dropped and overrun is set.
- FIFO pop on rd_en && !fifo_empty. rd_en while empty is ignored: no pointer change, no error.
- Simultaneous push and pop: fifo_count is unchanged and pointers wrap modulo FIFO_DEPTH.
- err_count increments on each rising edge of frame_error and saturates at 255.
- clr_status clears overrun and err_count. If clr_status coincides with a new overrun or error event, the event wins: overrun=1, err_count=1.
- enable does not affect the FIFO or the status logic.

## Timing
- phase_arm high in cycle t: center_tick high in cycle t+HALF, then t+HALF+k·CLKS_PER_BIT for k=1..FRAME_BITS+1. Each tick is exactly one cycle wide.
- busy: high from t+1 through the last tick cycle; low from the next cycle.
- Push visibility: valid in cycle t updates fifo_dout, fifo_empty and fifo_count from cycle t+1.
- Pop: rd_en in cycle t advances fifo_dout at t+1.
- Status: overrun and err_count update 1 cycle after the triggering event.
- Reset mid-frame: all outputs return to reset values on the next edge; any in-flight tick is cancelled.

## Test plan
- Tick sequence: CLKS_PER_BIT=16, FRAME_BITS=8, phase_arm at cycle 100 -> ticks exactly at 108, 124, …, 252 (10 ticks). busy is high for cycles 101..252.
- Re-arm: phase_arm at 100, then again at 130 -> tick at 108 and 124 only, then 138, 154, …, 282. No tick at 140.
- Full loopback: receiver driven with serial 0xA5 at 16 clk/bit -> one valid pulse. fifo_dout=0xA5, fifo_count=1; rd_en gives fifo_empty=1.
- Overrun: FIFO_DEPTH=4, push 0x01..0x05 without reads -> fifo_full=1, overrun=1. Reads return 0x01..0x04. Then clr_status -> overrun=0.
- Full boundary: with the FIFO full, valid and rd_en in the same cycle -> no overrun, fifo_count stays 4. The new byte is read last.
- Errors and reset: 3 stop-bit=0 frames -> err_count=3. Reset asserted mid-RUN -> next cycle center_tick=0, busy=0, err_count=0, fifo_empty=1.
